kband_result_mem_writer: RTL and testbench
==========================================

Name: kband_result_mem_writer

Overview:
- Packs a stream of 32-bit alignment result words from the KBand core into 128-bit lines.
- Writes each line into the 128-bit x 16384 single-port on-chip result memory through its write port: address, chipselect, write, writedata, byteenable and clken.
- The HPS reads the memory afterwards.
- Sits directly upstream of the on-chip memory. It provides buffering, addressing, end-of-stream flush and overflow protection.

Parameters:
- IN_W, 32: input word width. OUT_W must be an integer multiple of it.
- OUT_W, 128: memory data width.
- ADDR_W, 14: memory address width.
- DEPTH, 16384: number of memory lines usable, at most 2^ADDR_W.
- LANES = OUT_W/IN_W, default 4. Derived, not overridable.

Ports:
- clk, input, 1: the single clock.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle pulse that arms a new transfer.
- in_valid, input, 1: input word valid.
- in_data, input, IN_W: input word.
- in_last, input, 1: marks the final word of the stream. Qualified by in_valid.
- in_ready, output, 1: the block accepts a word when in_valid and in_ready are both 1.
- mem_address, output, ADDR_W: memory line address.
- mem_chipselect, output, 1: memory select.
- mem_write, output, 1: memory write strobe.
- mem_writedata, output, OUT_W: packed line.
- mem_byteenable, output, OUT_W/8: byte enables.
- mem_clken, output, 1: memory clock enable. Tied to 1.
- busy, output, 1: high in the ACCEPT and WRITE states.
- done, output, 1: high in the DONE state.
- overflow, output, 1: sticky. Set when the memory fills before in_last.
- words_written, output, ADDR_W+1: count of lines written in this transfer.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: all registered outputs and state clear immediately when reset_n falls. State returns to IDLE.
- Outputs: all outputs are registered except in_ready, which is decoded from state.
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - start moves to ACCEPT with lane_idx=0, lane mask=0, address=0, words_written=0, overflow=0.
- ACCEPT:
  - in_ready=1.
  - On each handshake, in_data is stored in lane lane_idx. Lane 0 is bits [IN_W-1:0]. The lane's IN_W/8 byte-enable bits are set.
  - If lane_idx==LANES-1 or in_last=1, move to WRITE and latch the last flag. Otherwise increment lane_idx.
- WRITE (exactly 1 cycle):
  - mem_chipselect=1 and mem_write=1 with the packed data and byte mask. in_ready=0.
  - Unfilled lanes drive writedata 0 and byteenable 0.
  - On exit: address increments by 1, words_written increments by 1, lane_idx and mask clear.
  - If the last flag is set, go to DONE.
  - Else if the address just written was DEPTH-1, set overflow=1 and go to DONE.
  - Else go back to ACCEPT.
- Write timing and throughput:
  - mem_write is asserted in the cycle after the handshake that completes the line.
  - mem_write is 0 in every other cycle.
  - Sustained throughput is LANES words per LANES+1 cycles.
- DONE:
  - in_ready=0. done=1.
  - Holds until start, which re-arms exactly as from IDLE.
- start in ACCEPT or WRITE:
  - Treated as an abort and re-arm. If start coincides with the WRITE cycle, that write still occurs.
  - The next cycle is in ACCEPT with address=0, counters cleared and any partial line discarded.
- Address range: the address never wraps. Once DEPTH lines are written, the block stops in DONE.
- Empty stream: not possible. in_last always accompanies a valid word, so a flush line always has at least 1 lane.
- Address output: mem_address is held stable while not writing. Its value is not otherwise meaningful.

Test Plan:
- Full line:
  - Stimulus: start, then words 0x11111111, 0x22222222, 0x33333333, 0x44444444 with in_last on the 4th.
  - Required: one write at address 0 with data 0x44444444_33333333_22222222_11111111 and byteenable 0xFFFF. Then done=1, words_written=1.
- Partial flush:
  - Stimulus: 6 words 0xA0..0xA5 with in_last on the 6th.
  - Required: address 0 written with byteenable 0xFFFF. Address 1 written with data 0x0..0_000000A5_000000A4 and byteenable 0x00FF. words_written=2.
- Backpressure and gaps:
  - Stimulus: in_valid held at 1 continuously, then a random in_valid gap pattern.
  - Required: in_ready=0 in every WRITE cycle. No word is lost or duplicated; the scoreboard compares memory contents word by word.
- Overflow:
  - Stimulus: DEPTH=4; 20 words without in_last.
  - Required: 4 writes to addresses 0..3, overflow=1, done=1, in_ready=0. Words 17..20 are not accepted.
- Abort:
  - Stimulus: 2 words, start pulse, then 4 new words with in_last.
  - Required: no write containing the first 2 words. One write at address 0 with the new 4 words. words_written=1.
- Async reset:
  - Stimulus: drive reset_n low during a WRITE cycle, mid-clock.
  - Required: mem_write, busy and in_ready drop to 0 before the next clock edge. After release the block sits in IDLE with all counters at 0.

Source files
------------

// File: rtl/kband_result_mem_writer_if.sv
// -----------------------------------------------------------------------------
// kband_result_mem_writer_if
//   Bundles the two buses of the result memory writer:
//     - the 32-bit result word stream from the KBand core (in_*)
//     - the write port of the 128-bit on-chip result memory (mem_*)
//   Stream handshake: a word moves on a rising clk edge where in_valid and
//   in_ready are both 1. in_data and in_last are only meaningful while
//   in_valid is 1, and in_valid does not depend on in_ready.
//   Modports:
//     master - the writer: consumes the stream, drives the memory port
//     slave  - the environment: produces the stream, observes the memory port
// -----------------------------------------------------------------------------
interface kband_result_mem_writer_if #(
   parameter int IN_W   = 32,
   parameter int OUT_W  = 128,
   parameter int ADDR_W = 14
);
   logic              in_valid;
   logic [IN_W-1:0]   in_data;
   logic              in_last;
   logic              in_ready;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_chipselect;
   logic              mem_write;
   logic [OUT_W-1:0]  mem_writedata;
   logic [OUT_W/8-1:0] mem_byteenable;
   logic              mem_clken;

   modport master (
      input  in_valid, in_data, in_last,
      output in_ready,
      output mem_address, mem_chipselect, mem_write,
      output mem_writedata, mem_byteenable, mem_clken
   );

   modport slave (
      output in_valid, in_data, in_last,
      input  in_ready,
      input  mem_address, mem_chipselect, mem_write,
      input  mem_writedata, mem_byteenable, mem_clken
   );
endinterface

// File: rtl/kband_result_mem_writer.sv
// -----------------------------------------------------------------------------
// kband_result_mem_writer
//   Packs LANES = OUT_W/IN_W result words into one memory line and writes the
//   line to consecutive addresses of the result memory, starting at 0 on every
//   start pulse. in_last flushes a partial line (unfilled lanes are written as
//   zero with byteenable 0). The address never wraps: after DEPTH lines the
//   block stops in DONE and raises the sticky overflow flag unless that last
//   line also carried in_last.
//   Ports:
//     clk, reset_n      - clock, asynchronous active-low reset
//     start             - one-cycle pulse, arms (or aborts and re-arms) a transfer
//     bus               - stream input and memory write port (master modport)
//     busy              - high in ACCEPT and WRITE
//     done              - high in DONE
//     overflow          - sticky, memory filled before in_last
//     words_written     - lines written in the current transfer
//     dbg_state         - current FSM state (0 IDLE, 1 ACCEPT, 2 WRITE, 3 DONE)
// -----------------------------------------------------------------------------
module kband_result_mem_writer #(
   parameter int IN_W   = 32,
   parameter int OUT_W  = 128,
   parameter int ADDR_W = 14,
   parameter int DEPTH  = 16384
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   kband_result_mem_writer_if.master bus,
   output logic                      busy,
   output logic                      done,
   output logic                      overflow,
   output logic [ADDR_W:0]           words_written,
   output logic [1:0]                dbg_state
);
   localparam int LANES  = OUT_W / IN_W;
   localparam int BPL    = IN_W / 8;
   localparam int BE_W   = OUT_W / 8;
   localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCEPT = 2'd1,
      S_WRITE  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t             r_state;
   logic [LIDX_W-1:0]  r_lane_idx;
   logic [OUT_W-1:0]   r_data;
   logic [BE_W-1:0]    r_be;
   logic               r_last;
   logic [ADDR_W-1:0]  r_addr;
   logic [ADDR_W:0]    r_words;
   logic               r_overflow;
   logic               r_busy;
   logic               r_done;
   logic               r_mem_cs;
   logic               r_mem_write;
   logic [OUT_W-1:0]   r_mem_wdata;
   logic [BE_W-1:0]    r_mem_be;

   logic               w_hs;
   logic               w_line_end;
   logic               w_at_top;
   logic [OUT_W-1:0]   w_data;
   logic [BE_W-1:0]    w_be;

   assign bus.in_ready = (r_state == S_ACCEPT);
   assign w_hs         = bus.in_valid && bus.in_ready;
   assign w_line_end   = (r_lane_idx == LIDX_W'(LANES - 1)) || bus.in_last;
   assign w_at_top     = (r_addr == ADDR_W'(DEPTH - 1));

   // Current line with the incoming word merged into lane r_lane_idx.
   always_comb begin
      w_data = r_data;
      w_be   = r_be;
      for (int l = 0; l < LANES; l++) begin
         if (r_lane_idx == LIDX_W'(l)) begin
            w_data[l*IN_W +: IN_W] = bus.in_data;
            w_be[l*BPL +: BPL]     = '1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_lane_idx  <= '0;
         r_data      <= '0;
         r_be        <= '0;
         r_last      <= 1'b0;
         r_addr      <= '0;
         r_words     <= '0;
         r_overflow  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_mem_cs    <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
      end else begin
         // The write strobe lives for exactly the WRITE cycle.
         r_mem_cs    <= 1'b0;
         r_mem_write <= 1'b0;
         if (start) begin
            // Arm from any state; a write already on the bus this cycle
            // completes because its outputs are registered.
            r_state    <= S_ACCEPT;
            r_lane_idx <= '0;
            r_data     <= '0;
            r_be       <= '0;
            r_last     <= 1'b0;
            r_addr     <= '0;
            r_words    <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
         end else begin
            case (r_state)
               S_ACCEPT: begin
                  if (w_hs) begin
                     r_data <= w_data;
                     r_be   <= w_be;
                     if (w_line_end) begin
                        r_state     <= S_WRITE;
                        r_last      <= bus.in_last;
                        r_mem_cs    <= 1'b1;
                        r_mem_write <= 1'b1;
                        r_mem_wdata <= w_data;
                        r_mem_be    <= w_be;
                     end else begin
                        r_lane_idx <= r_lane_idx + 1'b1;
                     end
                  end
               end
               S_WRITE: begin
                  r_words    <= r_words + 1'b1;
                  r_lane_idx <= '0;
                  r_data     <= '0;
                  r_be       <= '0;
                  // Hold at the top line instead of wrapping to 0.
                  if (!w_at_top) r_addr <= r_addr + 1'b1;
                  if (r_last) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else if (w_at_top) begin
                     r_state    <= S_DONE;
                     r_overflow <= 1'b1;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                  end else begin
                     r_state <= S_ACCEPT;
                  end
               end
               default: ;  // IDLE and DONE wait for start
            endcase
         end
      end
   end

   assign bus.mem_address    = r_addr;
   assign bus.mem_chipselect = r_mem_cs;
   assign bus.mem_write      = r_mem_write;
   assign bus.mem_writedata  = r_mem_wdata;
   assign bus.mem_byteenable = r_mem_be;
   assign bus.mem_clken      = 1'b1;
   assign busy               = r_busy;
   assign done               = r_done;
   assign overflow           = r_overflow;
   assign words_written      = r_words;
   assign dbg_state          = r_state;
endmodule

// File: tb/tb_kband_result_mem_writer.sv
module tb_kband_result_mem_writer;
  localparam int IN_W   = 32;
  localparam int OUT_W  = 128;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 4;
  localparam int EXP_W  = ADDR_W + OUT_W + OUT_W / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic busy;
  logic done;
  logic overflow;
  logic [ADDR_W:0] words_written;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  kband_result_mem_writer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus ();

  kband_result_mem_writer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .bus(bus),
    .busy(busy),
    .done(done),
    .overflow(overflow),
    .words_written(words_written),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [OUT_W-1:0] d,
                          input logic [OUT_W/8-1:0] be);
    exp_q.push_back({a, d, be});
  endtask

  // Reference packing of words base+0 .. base+n-1, last on the final word.
  task automatic model_lines(input int n, input logic [31:0] base);
    logic [OUT_W-1:0] d;
    logic [OUT_W/8-1:0] be;
    logic [ADDR_W-1:0] a;
    int lane;
    d = '0; be = '0; a = '0; lane = 0;
    for (int i = 0; i < n; i++) begin
      d[lane*32 +: 32] = base + 32'(i);
      be[lane*4 +: 4] = 4'hF;
      if (lane == 3 || i == n - 1) begin
        push_exp(a, d, be);
        a = a + 1'b1;
        d = '0; be = '0; lane = 0;
      end else begin
        lane++;
      end
    end
  endtask

  // Monitor: every memory write is compared against the head of exp_q.
  always @(negedge clk) begin
    if (reset_n && bus.mem_write) begin
      check("ready_in_write", bus.in_ready, 0);
      check("cs_in_write", bus.mem_chipselect, 1);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {bus.mem_address, bus.mem_writedata, bus.mem_byteenable}, 0);
      end else begin
        check("mem_line", {bus.mem_address, bus.mem_writedata, bus.mem_byteenable},
              exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    bit ok;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    for (int n = 0; n < 64 && !ok; n++) begin
      if (bus.in_ready) ok = 1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic send_stream(input int n, input logic [31:0] base, input bit last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) idle($urandom_range(0, 3));
      send_word(base + 32'(i), last && (i == n - 1));
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    reset_n = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    idle(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", bus.in_ready, 0);
    check("rst_write", bus.mem_write, 0);
    check("rst_ww", words_written, 0);
    check("rst_ovf", overflow, 0);
    check("rst_clken", bus.mem_clken, 1);
    reset_n = 1'b1;
    idle(2);
    check("idle_state", dbg_state, 0);

    // Full line
    pulse_start();
    check("armed_busy", busy, 1);
    push_exp(14'd0, 128'h44444444_33333333_22222222_11111111, 16'hFFFF);
    send_word(32'h11111111, 0);
    send_word(32'h22222222, 0);
    send_word(32'h33333333, 0);
    send_word(32'h44444444, 1);
    wait_done();
    check("full_ww", words_written, 1);
    check("full_ready", bus.in_ready, 0);
    check("full_busy", busy, 0);
    check("full_ovf", overflow, 0);

    // Partial flush
    pulse_start();
    push_exp(14'd0, 128'h000000A3_000000A2_000000A1_000000A0, 16'hFFFF);
    push_exp(14'd1, 128'h00000000_00000000_000000A5_000000A4, 16'h00FF);
    send_stream(6, 32'hA0, 1, 0);
    wait_done();
    check("partial_ww", words_written, 2);

    // Continuous valid
    pulse_start();
    model_lines(12, 32'hC0000000);
    send_stream(12, 32'hC0000000, 1, 0);
    wait_done();
    check("cont_ww", words_written, 3);

    // Random gaps
    pulse_start();
    model_lines(10, 32'hD0000000);
    send_stream(10, 32'hD0000000, 1, 1);
    wait_done();
    check("gap_ww", words_written, 3);

    // Last line lands exactly on DEPTH-1: no overflow
    pulse_start();
    model_lines(16, 32'hE0000000);
    send_stream(16, 32'hE0000000, 1, 0);
    wait_done();
    check("top_last_ovf", overflow, 0);
    check("top_last_ww", words_written, 4);

    // Overflow: 20 words, none marked last
    pulse_start();
    model_lines(16, 32'hF0000000);
    send_stream(16, 32'hF0000000, 0, 0);
    bus.in_valid = 1'b1;
    bus.in_data = 32'hF0000010;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.in_ready) acc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("ovf_no_accept", acc, 0);
    check("ovf_flag", overflow, 1);
    check("ovf_done", done, 1);
    check("ovf_ready", bus.in_ready, 0);
    check("ovf_ww", words_written, 4);

    // Abort: 2 words, re-arm, 4 new words
    pulse_start();
    check("re_arm_ovf", overflow, 0);
    send_word(32'hB0, 0);
    send_word(32'hB1, 0);
    pulse_start();
    push_exp(14'd0, 128'h000000D3_000000D2_000000D1_000000D0, 16'hFFFF);
    send_stream(4, 32'hD0, 1, 0);
    wait_done();
    check("abort_ww", words_written, 1);

    // Async reset during a WRITE cycle
    pulse_start();
    send_stream(3, 32'h70, 0, 0);
    bus.in_valid = 1'b1;
    bus.in_data = 32'h73;
    bus.in_last = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_write", bus.mem_write, 1);
    check("pre_rst_busy", busy, 1);
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("arst_write", bus.mem_write, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", bus.in_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    check("post_rst_state", dbg_state, 0);
    check("post_rst_ww", words_written, 0);
    check("post_rst_done", done, 0);
    check("post_rst_write", bus.mem_write, 0);

    // Fresh transfer after reset starts again at address 0
    pulse_start();
    push_exp(14'd0, 128'h00000083_00000082_00000081_00000080, 16'hFFFF);
    send_stream(4, 32'h80, 1, 0);
    wait_done();
    check("after_rst_ww", words_written, 1);

    idle(3);
    check("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
